pc_fetch_unit: RTL

Program-counter register and instruction-fetch sequencer. Holds the architectural PC, drives it to the PC+4 adder and to instruction memory, and on each retirement loads the next PC from a jump, a branch, or the adder's PC+4 result. Fetch uses a req/ready handshake with instruction memory. Each instruction is presented to decode until the core releases it.

---
 rtl/pc_fetch_pkg.sv | 19 +
 rtl/pc_next_sel.sv | 28 ++
 rtl/pc_fetch_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch sequencer.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2
    } sel_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: jump over taken branch over sequential PC+4.
module pc_next_sel
    import pc_fetch_pkg::*;
(
    input  logic        jmp,
    input  logic        br_taken,
    input  logic [31:0] seq_pc,
    input  logic [31:0] br_target,
    input  logic [31:0] jmp_target,
    output logic [31:0] next_pc,
    output sel_e        sel,
    output logic        misaligned
);

    always_comb begin
        sel     = SEL_SEQ;
        next_pc = seq_pc;
        if (jmp) begin
            sel     = SEL_JMP;
            next_pc = jmp_target;
        end else if (br_taken) begin
            sel     = SEL_BR;
            next_pc = br_target;
        end
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter register and req/ready instruction-fetch sequencer.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        misalign,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic        imem_req_q, imem_req_d;
    logic        misalign_q, misalign_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] next_pc;
    sel_e        next_sel;
    logic        next_misaligned;

    pc_next_sel u_next_sel (
        .jmp        (jmp),
        .br_taken   (br_taken),
        .seq_pc     (pc_plus4),
        .br_target  (br_target),
        .jmp_target (jmp_target),
        .next_pc    (next_pc),
        .sel        (next_sel),
        .misaligned (next_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (imem_ready) state_d = EXEC;
            EXEC:  if (!stall) state_d = next_misaligned ? HALT : FETCH;
            HALT:  state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        imem_req_d   = imem_req_q;
        misalign_d   = misalign_q;
        retired_d    = retired_q;
        unique case (state_q)
            IDLE: imem_req_d = 1'b1;
            FETCH: begin
                if (imem_ready) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    imem_req_d   = 1'b0;
                end
            end
            EXEC: begin
                if (!stall) begin
                    inst_valid_d = 1'b0;
                    if (next_misaligned) begin
                        // Faulting target: PC and retire count keep the last good values.
                        misalign_d = 1'b1;
                        imem_req_d = 1'b0;
                    end else if (next_sel inside {SEL_SEQ, SEL_BR, SEL_JMP}) begin
                        pc_d       = next_pc;
                        retired_d  = retired_q + 32'd1;
                        imem_req_d = 1'b1;
                    end
                end
            end
            HALT: begin
                imem_req_d   = 1'b0;
                inst_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            misalign_q   <= 1'b0;
            retired_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
            misalign_q   <= misalign_d;
            retired_q    <= retired_d;
        end
    end

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign imem_req   = imem_req_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign misalign   = misalign_q;
    assign retired    = retired_q;

endmodule
